// File: rtl/muldiv_pkg.sv
// Shared constants for the M-extension multiply/divide sequencer and decoder.
package muldiv_pkg;

  localparam int unsigned F3_W = 3;
  localparam int unsigned RD_W = 5;

  localparam logic [F3_W-1:0] MD_MUL    = 3'b000;
  localparam logic [F3_W-1:0] MD_MULH   = 3'b001;
  localparam logic [F3_W-1:0] MD_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] MD_MULHU  = 3'b011;
  localparam logic [F3_W-1:0] MD_DIV    = 3'b100;
  localparam logic [F3_W-1:0] MD_DIVU   = 3'b101;
  localparam logic [F3_W-1:0] MD_REM    = 3'b110;
  localparam logic [F3_W-1:0] MD_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider on a shared accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_out
);

  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Multiply: acc = {product_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    upper   = acc_in[2*WIDTH:WIDTH];
    sum     = upper + {1'b0, operand};
    shifted = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, shifted} - {2'b00, operand};
    if (is_div) begin
      if (diff[WIDTH+1]) acc_out = {shifted, acc_in[WIDTH-2:0], 1'b0};
      else               acc_out = {diff[WIDTH:0], acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {1'b0, (acc_in[0] ? sum : upper), acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RISC-V M-extension sequencer: iterative multiply/divide with pipeline stall.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_addr_i,
  input  logic             flush,
  output logic             stall_o,
  output logic             resp_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_addr_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2*WIDTH+1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [F3_W-1:0]   f3_q, f3_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [RD_W-1:0]   rd_out_q, rd_out_d;

  logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]  a_mag, b_mag, dval, dres;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (f3_q[2]),
    .acc_in  (acc_q),
    .operand (opb_q),
    .acc_out (acc_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    // Operand sign handling, evaluated against the incoming request.
    a_sgn    = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
               (funct3 == MD_DIV)  || (funct3 == MD_REM);
    b_sgn    = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    a_neg    = a_sgn & op_a[WIDTH-1];
    b_neg    = b_sgn & op_b[WIDTH-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = funct3[2] & (op_b == '0);
    div_ovf  = funct3[2] & b_sgn & (op_a == MIN_NEG) & (&op_b);

    prod = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    dval = f3_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    dres = neg_q ? -dval : dval;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          f3_d  = funct3;
          rd_d  = rd_addr_i;
          opb_d = b_mag;
          neg_d = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d = {{(WIDTH+1){1'b0}}, a_mag};
          cnt_d = CNT_W'(WIDTH-1);
          state_d = ST_CALC;
          // Divide-by-zero and signed overflow resolve without iterating.
          if (div_zero) begin
            result_d = funct3[1] ? op_a : '1;
            rd_out_d = rd_addr_i;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : op_a;
            rd_out_d = rd_addr_i;
            state_d  = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (f3_q[2])              result_d = dres;
          else if (f3_q == MD_MUL)  result_d = prod[WIDTH-1:0];
          else                      result_d = prod[2*WIDTH-1:WIDTH];
          rd_out_d = rd_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from state so a flush or request acts in the same cycle.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    stall_o    = ((state_q == ST_IDLE) & req_valid & !flush) |
                 (state_q == ST_CALC) | (state_q == ST_FIXUP);
    resp_valid = (state_q == ST_DONE) & !flush;
    result     = result_q;
    rd_addr_o  = rd_out_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_addr_i;
  logic        flush;
  logic        stall_o;
  logic        resp_valid;
  logic [31:0] result;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .rd_addr_i  (rd_addr_i),
    .flush      (flush),
    .stall_o    (stall_o),
    .resp_valid (resp_valid),
    .result     (result),
    .rd_addr_o  (rd_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is just past a rising edge in IDLE; this cycle is cycle 0.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output int stalls);
    req_valid = 1'b1; funct3 = f; op_a = a; op_b = b; rd_addr_i = rd;
    step();
    req_valid = 1'b0;
    lat = -1; stalls = 0; res = 'x; rdo = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; res = result; rdo = rd_addr_o;
        break;
      end
      if (stall_o) stalls++;
    end
  endtask

  int          lat, st;
  logic [31:0] res;
  logic [4:0]  rdo;
  logic        seen;

  initial begin
    reset = 1'b0; req_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    rd_addr_i = '0; flush = 1'b0;
    repeat (2) step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk); reset = 1'b1;
    step();

    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, lat, res, rdo, st);
    chk("mul_lat", 32'(lat), 32'd34);
    chk("mul_stall_cycles", 32'(st), 32'd33);
    chk("mul_res", res, 32'hFFFF_FFEB);
    chk("mul_rd", 32'(rdo), 32'd3);
    @(negedge clk);
    chk("mul_pulse", 32'(resp_valid), 32'd0);
    step();

    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, lat, res, rdo, st);
    chk("mulhu_res", res, 32'hFFFF_FFFE);
    step();
    run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, lat, res, rdo, st);
    chk("mulh_res", res, 32'h0000_0000);
    step();
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat, res, rdo, st);
    chk("mulhsu_res", res, 32'hFFFF_FFFF);
    step();

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, lat, res, rdo, st);
    chk("div_lat", 32'(lat), 32'd34);
    chk("div_res", res, 32'hFFFF_FFFD);
    step();
    run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, lat, res, rdo, st);
    chk("rem_res", res, 32'hFFFF_FFFF);
    step();
    run_op(MD_DIVU, 32'd100, 32'd7, 5'd9, lat, res, rdo, st);
    chk("divu_res", res, 32'd14);
    step();
    run_op(MD_REMU, 32'd100, 32'd7, 5'd10, lat, res, rdo, st);
    chk("remu_res", res, 32'd2);
    chk("remu_rd", 32'(rdo), 32'd10);
    step();

    run_op(MD_DIV, 32'd5, 32'd0, 5'd11, lat, res, rdo, st);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_stall_cycles", 32'(st), 32'd0);
    chk("div0_res", res, 32'hFFFF_FFFF);
    step();
    run_op(MD_REM, 32'd5, 32'd0, 5'd12, lat, res, rdo, st);
    chk("rem0_lat", 32'(lat), 32'd1);
    chk("rem0_res", res, 32'd5);
    step();
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, lat, res, rdo, st);
    chk("divovf_lat", 32'(lat), 32'd1);
    chk("divovf_res", res, 32'h8000_0000);
    step();
    run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, res, rdo, st);
    chk("removf_res", res, 32'd0);
    step();
    run_op(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, lat, res, rdo, st);
    chk("divu_noovf_lat", 32'(lat), 32'd34);
    chk("divu_noovf_res", res, 32'd0);
    step();

    // Flush landing in DONE kills the response in that same cycle.
    req_valid = 1'b1; funct3 = MD_DIVU; op_a = 32'd9; op_b = 32'd0; rd_addr_i = 5'd16;
    step();
    req_valid = 1'b0;
    chk("done_ready", 32'(req_ready), 32'd0);
    flush = 1'b1;
    #1;
    chk("done_flush_resp", 32'(resp_valid), 32'd0);
    step();
    flush = 1'b0;
    chk("done_flush_ready", 32'(req_ready), 32'd1);

    // Flush in cycle 10 of a DIV, then an immediate new MUL.
    req_valid = 1'b1; funct3 = MD_DIV; op_a = 32'd1000; op_b = 32'd3; rd_addr_i = 5'd17;
    step();
    req_valid = 1'b0;
    repeat (9) step();
    chk("flush_busy_stall", 32'(stall_o), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_resp", 32'(resp_valid), 32'd0);
    run_op(MD_MUL, 32'd3, 32'd4, 5'd18, lat, res, rdo, st);
    chk("post_flush_lat", 32'(lat), 32'd34);
    chk("post_flush_res", res, 32'd12);
    chk("post_flush_rd", 32'(rdo), 32'd18);
    seen = 1'b0;
    step();
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("idle_no_resp", 32'(seen), 32'd0);
    step();

    // Asynchronous reset in cycle 5 of a MUL.
    req_valid = 1'b1; funct3 = MD_MUL; op_a = 32'd11; op_b = 32'd13; rd_addr_i = 5'd19;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_resp", 32'(resp_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk); reset = 1'b1;
    step();
    run_op(MD_MUL, 32'd11, 32'd13, 5'd20, lat, res, rdo, st);
    chk("post_rst_lat", 32'(lat), 32'd34);
    chk("post_rst_res", res, 32'd143);
    chk("post_rst_rd", 32'(rdo), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for RISC-V M-extension operations executed alongside the execute-stage ALU. It accepts one operation per request, runs an iterative shift-add multiplier or restoring divider over WIDTH cycles, and holds the pipeline with a stall signal while it is busy. It releases the result on a single-cycle response that the EX/MEM register captures.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  M-op present in execute (decoder: opcode OP, funct7=0000001)
- req_ready  out  1  sequencer idle, can accept
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  WIDTH  rs1 operand (post-forwarding)
- op_b  in  WIDTH  rs2 operand
- rd_addr_i  in  5  destination register
- flush  in  1  kill in-flight op (branch redirect)
- stall_o  out  1  freeze PC, IF/ID, ID/EX
- resp_valid  out  1  result valid this cycle
- result  out  WIDTH  selected result
- rd_addr_o  out  5  destination of resp

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid & !flush: latch funct3 and rd_addr_i.
  - Latch |op_a| / |op_b| magnitudes and signs. op_a is signed for MULH, MULHSU, DIV, REM. op_b is signed for MULH, DIV, REM.
  - Load the counter with WIDTH-1 and go to CALC.
  - Exception: special divides go directly to DONE.
- Special divides, decided at accept:
  - op_b=0: quotient = all ones; remainder = op_a.
  - Signed overflow (op_a=1<<(WIDTH-1), op_b=all ones, DIV/REM): quotient = op_a; remainder = 0.
- CALC, one step per cycle:
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper half of a 2*WIDTH accumulator; then shift right by 1.
  - Divide: shift the remainder left and bring in the next dividend bit; trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise set it to 0.
  - Counter decrements each cycle. At counter 0, go to FIXUP.
- FIXUP:
  - Negate the product when the operand signs differ.
  - Negate the quotient when signs differ (signed DIV).
  - Negate the remainder when the dividend is negative (signed REM).
  - Select the output: MUL gives the low half; MULH/MULHSU/MULHU give the high half; DIV/DIVU give the quotient; REM/REMU give the remainder. Go to DONE.
- DONE: resp_valid=1, result/rd_addr_o driven; next state IDLE.
- flush in CALC/FIXUP/DONE: next state IDLE, no resp_valid is produced afterwards. A flush in DONE suppresses resp_valid in that same cycle.
- req_valid outside IDLE is ignored (no queueing).
- Arithmetic: the multiply accumulator is 2*WIDTH+1 bits to hold the carry; the divider remainder is WIDTH+1 bits; all magnitudes are unsigned.

## Timing
- Reset values: state IDLE, req_ready=1, stall_o=0, resp_valid=0, result=0, rd_addr_o=0. All internal registers are cleared.
- Reset mid-operation aborts immediately (asynchronous) and produces no response.
- stall_o = (IDLE & req_valid & !flush) | CALC | FIXUP. It is combinational from req_valid in IDLE.
- stall_o is 0 in DONE, so the pipeline advances and EX/MEM captures the result on the DONE edge.
- Latency for a normal op, with the accept edge as cycle 0:
  - CALC occupies cycles 1..WIDTH.
  - FIXUP is cycle WIDTH+1.
  - resp_valid is high in cycle WIDTH+2 (34 for WIDTH=32).
- Latency for a special divide: resp_valid is high in cycle 1.
- resp_valid is a one-cycle pulse with no backpressure.
- Back-to-back: the earliest next accept is the cycle after DONE.
- result and rd_addr_o hold their last value outside DONE; consumers qualify them with resp_valid.

## Structure
- Shared package muldiv_pkg holds:
  - funct3 constants: MD_MUL..MD_REMU.
  - State encoding: 2-bit constants ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE.
  - An M-extension funct7 constant, also used by the decoder.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-shift or subtract-shift selected by an is_div input). The FSM, counter, sign bookkeeping and output registers stay in muldiv_seq.

## Test plan
- MUL 7×(-3) (op_b=0xFFFFFFFD): stall_o high for 33 cycles; resp_valid in cycle 34; result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULH with the same operands gives 0x00000000. MULHSU(-1, 0xFFFFFFFF) gives 0xFFFFFFFF.
- DIV -7/2: result=0xFFFFFFFD (-3). REM -7/2: result=0xFFFFFFFF (-1). DIVU 100/7 gives 14. REMU 100/7 gives 2.
- DIV x/0 with op_a=5: resp_valid in cycle 1, result=0xFFFFFFFF. REM 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000 in cycle 1. REM with the same operands gives 0.
- flush asserted in cycle 10 of a DIV: IDLE next cycle, no resp_valid, req_ready=1. A new MUL 3×4 accepted immediately returns 12.
- reset driven low in cycle 5 of a MUL: all outputs go to reset values without waiting for a clock edge. After release, a fresh op completes normally.
